rx_dcm_seq: RTL and testbench

- Reset/lock sequencer for the receive-clock DCM.
- Pulses the DCM reset for a guaranteed minimum width, then waits for LOCKED with a timeout and bounded retries.
- Qualifies lock as stable before releasing the rx-engine datapath reset, and re-sequences on loss of lock.
- Runs on the free-running input clock, never on a DCM output.

---
 rtl/rx_pkg.sv | 19 +
 rtl/rx_dcm_seq_if.sv | 29 ++
 rtl/sync2.sv | 25 ++
 rtl/rx_dcm_seq.sv | 120 ++++++++++++
 tb/tb_rx_dcm_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the rx clocking blocks.
// Sequencer state encoding and default timing.
package rx_pkg;

    typedef enum logic [2:0] {
        ST_RESET_DCM = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    localparam int unsigned DEF_RST_HOLD    = 8;
    localparam int unsigned DEF_LOCK_TMO    = 4096;
    localparam int unsigned DEF_LOCK_STABLE = 64;
    localparam int unsigned DEF_MAX_RETRIES = 7;
    localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/rx_dcm_seq_if.sv
// Control/status bundle between the DCM sequencer and its user.
// master is the sequencer side.
interface rx_dcm_seq_if;

    logic       dcm_locked;
    logic       restart;
    logic       dcm_rst;
    logic       rx_rst;
    logic       clk_ready;
    logic       lock_fail;
    logic       lock_lost;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    modport master (
        input  dcm_locked, restart,
        output dcm_rst, rx_rst, clk_ready,
        output lock_fail, lock_lost,
        output retry_cnt, state
    );

    modport slave (
        output dcm_locked, restart,
        input  dcm_rst, rx_rst, clk_ready,
        input  lock_fail, lock_lost,
        input  retry_cnt, state
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
// Reusable for any single-bit CDC input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/rx_dcm_seq.sv
// Reset/lock sequencer for the rx DCM: reset pulse, lock wait with
// retries, lock qualification, loss-of-lock recovery.
module rx_dcm_seq
    import rx_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD,
    parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TMO,
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE,
    parameter int unsigned MAX_RETRIES        = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W              = DEF_CNT_W
) (
    input  logic          rxclk_in,
    input  logic          reset,
    rx_dcm_seq_if.master  bus
);

    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_END  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       MAX_R    = 4'(MAX_RETRIES);

    logic             lk;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             dcm_rst_q, dcm_rst_d;
    logic             rx_rst_q, rx_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             lost_q, lost_d;

    sync2 u_lock_sync (
        .clk   (rxclk_in),
        .rst_n (reset),
        .d     (bus.dcm_locked),
        .q     (lk)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        if (bus.restart) begin
            state_d = ST_RESET_DCM;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_DCM: begin
                    if (cnt_q == HOLD_END) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // a lock seen on the timeout cycle still wins
                    if (lk) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TMO_END) begin
                        if (retry_q >= MAX_R) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RESET_DCM;
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lk) state_d = ST_WAIT_LOCK;
                    else if (cnt_q == STB_END) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!lk) begin
                        state_d = ST_RESET_DCM;
                        retry_d = '0;
                        lost_d  = 1'b1;
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_RESET_DCM;
            endcase
        end

        if (bus.restart || (state_d != state_q)) cnt_d = '0;
        else cnt_d = cnt_q + CNT_W'(1);

        // outputs follow the state being entered, so they are registered
        dcm_rst_d = (state_d == ST_RESET_DCM) || (state_d == ST_FAIL);
        rx_rst_d  = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge rxclk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RESET_DCM;
            cnt_q     <= '0;
            retry_q   <= '0;
            dcm_rst_q <= 1'b1;
            rx_rst_q  <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            dcm_rst_q <= dcm_rst_d;
            rx_rst_q  <= rx_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
            lost_q    <= lost_d;
        end
    end

    assign bus.dcm_rst   = dcm_rst_q;
    assign bus.rx_rst    = rx_rst_q;
    assign bus.clk_ready = ready_q;
    assign bus.lock_fail = fail_q;
    assign bus.lock_lost = lost_q;
    assign bus.retry_cnt = retry_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_rx_dcm_seq.sv
// Bench for rx_dcm_seq: directed scenarios plus a randomized run
// against a cycle-level behavioural model.
module tb_rx_dcm_seq;

    localparam int HOLD = 4;
    localparam int TMO  = 32;
    localparam int STB  = 8;
    localparam int MAXR = 2;
    localparam logic [11:0] RST_VEC = 12'b000_0000_1_1_0_0_0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    int m_phase, m_time, m_retry;
    bit m_lost, m_s1, m_s2;

    rx_dcm_seq_if bus ();

    rx_dcm_seq #(
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_TIMEOUT       (TMO),
        .LOCK_STABLE_CYCLES (STB),
        .MAX_RETRIES        (MAXR),
        .CNT_W              (16)
    ) dut (
        .rxclk_in (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_phase = 0;
        m_time  = 0;
        m_retry = 0;
        m_lost  = 0;
        m_s1    = 0;
        m_s2    = 0;
    endfunction

    // lk is dcm_locked delayed by two sampling edges
    function automatic void model_update();
        int nxt;
        bit lk;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.dcm_locked;
        nxt = m_phase;
        m_lost = 0;
        if (bus.restart) begin
            nxt = 0;
            m_retry = 0;
        end else begin
            case (m_phase)
                0: if (m_time + 1 >= HOLD) nxt = 1;
                1: begin
                    if (lk) nxt = 2;
                    else if (m_time + 1 >= TMO) begin
                        if (m_retry == MAXR) nxt = 4;
                        else begin
                            m_retry++;
                            nxt = 0;
                        end
                    end
                end
                2: begin
                    if (!lk) nxt = 1;
                    else if (m_time + 1 >= STB) nxt = 3;
                end
                3: begin
                    if (!lk) begin
                        nxt = 0;
                        m_retry = 0;
                        m_lost = 1;
                    end
                end
                default: nxt = m_phase;
            endcase
        end
        m_time = (bus.restart || nxt != m_phase) ? 0 : m_time + 1;
        m_phase = nxt;
    endfunction

    function automatic logic [11:0] exp_vec();
        bit d, r;
        d = (m_phase == 0) || (m_phase == 4);
        r = (m_phase != 3);
        return {3'(m_phase), 4'(m_retry), d, r, m_phase == 3,
                m_phase == 4, m_lost};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {bus.state, bus.retry_cnt, bus.dcm_rst, bus.rx_rst,
                bus.clk_ready, bus.lock_fail, bus.lock_lost};
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.dcm_locked = 1'b0;
        bus.restart = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic reach_run(output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.clk_ready) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.dcm_locked = 1'b0;
        bus.restart = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_values got=%b want=%b", dut_vec(), RST_VEC);
        end
    endtask

    task automatic test_lock_up();
        int hi, n;
        apply_reset();
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.dcm_rst) hi++;
            step();
        end
        n_checks++;
        if (hi !== HOLD) begin
            n_fail++;
            $display("FAIL lockup_rst_width got=%0d want=%0d", hi, HOLD);
        end
        bus.dcm_locked = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (bus.clk_ready) break;
        end
        n_checks++;
        if (n !== 3 + STB) begin
            n_fail++;
            $display("FAIL lockup_latency got=%0d want=%0d", n, 3 + STB);
        end
        n_checks++;
        if ({bus.rx_rst, bus.retry_cnt, bus.state} !== {1'b0, 4'd0, 3'd3}) begin
            n_fail++;
            $display("FAIL lockup_run got=%b want=%b",
                     {bus.rx_rst, bus.retry_cnt, bus.state}, {1'b0, 4'd0, 3'd3});
        end
    endtask

    task automatic test_timeout_fail();
        int att, pos;
        logic [11:0] exp;
        apply_reset();
        for (int c = 0; c < 120; c++) begin
            att = c / (HOLD + TMO);
            pos = c % (HOLD + TMO);
            if (att <= MAXR)
                exp = {(pos < HOLD) ? 3'd0 : 3'd1, 4'(att), pos < HOLD,
                       1'b1, 1'b0, 1'b0, 1'b0};
            else
                exp = {3'd4, 4'(MAXR), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("FAIL timeout_c%0d got=%b want=%b", c, dut_vec(), exp);
            end
            bus.dcm_locked = (c >= 110);
            step();
        end
    endtask

    task automatic test_restart();
        int hi;
        bus.dcm_locked = 1'b0;
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        n_checks++;
        if ({bus.lock_fail, bus.retry_cnt, bus.state, bus.dcm_rst}
            !== {1'b0, 4'd0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_from_fail got=%b want=%b",
                     {bus.lock_fail, bus.retry_cnt, bus.state, bus.dcm_rst},
                     {1'b0, 4'd0, 3'd0, 1'b1});
        end
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.dcm_rst) break;
            hi++;
            step();
        end
        n_checks++;
        if (hi !== HOLD) begin
            n_fail++;
            $display("FAIL restart_pulse got=%0d want=%0d", hi, HOLD);
        end
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.dcm_rst) hi++;
            if (i == 2) bus.restart = 1'b1;
            step();
        end
        bus.restart = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.dcm_rst) break;
            hi++;
            step();
        end
        n_checks++;
        if (hi !== 3 + HOLD) begin
            n_fail++;
            $display("FAIL restart_stretch got=%0d want=%0d", hi, 3 + HOLD);
        end
    endtask

    task automatic test_lock_loss();
        bit ok;
        int n, hi;
        apply_reset();
        bus.dcm_locked = 1'b1;
        reach_run(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL loss_reach_run got=0 want=1");
        end
        bus.dcm_locked = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (bus.lock_lost) break;
        end
        n_checks++;
        if (n !== 3) begin
            n_fail++;
            $display("FAIL loss_latency got=%0d want=3", n);
        end
        n_checks++;
        if ({bus.rx_rst, bus.clk_ready, bus.dcm_rst, bus.retry_cnt}
            !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL loss_outputs got=%b want=%b",
                     {bus.rx_rst, bus.clk_ready, bus.dcm_rst, bus.retry_cnt},
                     {1'b1, 1'b0, 1'b1, 4'd0});
        end
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.dcm_rst) break;
            hi++;
            if (hi == 2) begin
                n_checks++;
                if (bus.lock_lost !== 1'b0) begin
                    n_fail++;
                    $display("FAIL loss_pulse_width got=1 want=0");
                end
            end
            step();
        end
        n_checks++;
        if (hi !== HOLD) begin
            n_fail++;
            $display("FAIL loss_rst_width got=%0d want=%0d", hi, HOLD);
        end
    endtask

    task automatic test_glitch();
        int n;
        apply_reset();
        bus.dcm_locked = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.state == 3'd2) break;
        end
        repeat (3) step();
        bus.dcm_locked = 1'b0;
        step();
        bus.dcm_locked = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.state, bus.retry_cnt} !== {3'd1, 4'd0}) begin
            n_fail++;
            $display("FAIL glitch_back_to_wait got=%b want=%b",
                     {bus.state, bus.retry_cnt}, {3'd1, 4'd0});
        end
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            n++;
            if (bus.clk_ready) break;
        end
        n_checks++;
        if (n !== 1 + STB) begin
            n_fail++;
            $display("FAIL glitch_fresh_count got=%0d want=%0d", n, 1 + STB);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        apply_reset();
        bus.dcm_locked = 1'b1;
        reach_run(ok);
        n_checks++;
        if (bus.state !== 3'd3) begin
            n_fail++;
            $display("FAIL async_pre_run got=%0d want=3", bus.state);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_reset got=%b want=%b", dut_vec(), RST_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int cyc, len, shown;
        bit lvl;
        apply_reset();
        cyc = 0;
        shown = 0;
        while (cyc < 3000) begin
            lvl = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 50);
            for (int i = 0; i < len; i++) begin
                bus.dcm_locked = lvl;
                bus.restart = ($urandom_range(0, 99) == 0);
                step();
                cyc++;
                n_checks++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++;
                    if (shown < 10)
                        $display("FAIL random_c%0d got=%b want=%b",
                                 cyc, dut_vec(), exp_vec());
                    shown++;
                end
            end
        end
        bus.restart = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock_up();
        test_timeout_fail();
        test_restart();
        test_lock_loss();
        test_glitch();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
